// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection, external hold,
//   flush (branch kill) handling and saturating stall/bubble counters.
//
// Parameters
//   XLEN  datapath width
//   CNTW  performance counter width
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   id_*                       decode-stage instruction, operands, control
//   flush                      taken-branch kill: load a bubble next edge
//   hold                       external freeze: EX registers keep their value
//   ex_*                       registered EX-stage copies of the id_* fields
//   stall                      (hold | load_use) & ~flush, combinational
//   pc_write, ifid_write       ~stall, freeze PC and IF/ID while stalling
//   stall_count, bubble_count  saturating counters
// ----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [3:0]      id_funct,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_MemtoReg,
  input  logic            id_ALUSrc,
  input  logic            id_Branch,
  input  logic [1:0]      id_ALUOp,

  input  logic            flush,
  input  logic            hold,

  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_funct,
  output logic            ex_RegWrite,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            ex_MemtoReg,
  output logic            ex_ALUSrc,
  output logic            ex_Branch,
  output logic [1:0]      ex_ALUOp,

  output logic            stall,
  output logic            pc_write,
  output logic            ifid_write,

  output logic [CNTW-1:0] stall_count,
  output logic [CNTW-1:0] bubble_count
);

  // Action taken by the EX register bank on the coming edge.
  typedef enum logic [2:0] {
    UPD_RESET,     // clear everything including counters
    UPD_FLUSH,     // counted bubble, branch kill
    UPD_HOLD,      // keep all EX registers
    UPD_LOAD_USE,  // counted bubble, ID/IF frozen
    UPD_LOAD,      // latch the decode instruction
    UPD_IDLE       // uncounted bubble, nothing valid in ID
  } upd_e;

  upd_e upd;
  logic load_use;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == '1) ? v : v + CNTW'(1);
  endfunction

  // Hazard detection looks only at the current EX registers, so a
  // dependent instruction sees at most one bubble: after the bubble the
  // load has moved on and ex_valid is 0.
  always_comb begin
    load_use = ex_valid && ex_MemRead && (ex_rd != 5'd0) && id_valid &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    stall      = (hold || load_use) && !flush;
    pc_write   = !stall;
    ifid_write = !stall;

    upd = UPD_LOAD;
    if (!rst_n)        upd = UPD_RESET;
    else if (flush)    upd = UPD_FLUSH;
    else if (hold)     upd = UPD_HOLD;
    else if (load_use) upd = UPD_LOAD_USE;
    else if (!id_valid) upd = UPD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (stall)
        stall_count <= sat_inc(stall_count);
      if ((upd == UPD_FLUSH) || (upd == UPD_LOAD_USE))
        bubble_count <= sat_inc(bubble_count);
    end
  end

  always_ff @(posedge clk) begin
    case (upd)
      UPD_HOLD: begin
        // all EX registers retain their values
      end
      UPD_LOAD: begin
        ex_valid    <= 1'b1;
        ex_pc       <= id_pc;
        ex_rs1_data <= id_rs1_data;
        ex_rs2_data <= id_rs2_data;
        ex_imm      <= id_imm;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_funct    <= id_funct;
        ex_RegWrite <= id_RegWrite;
        ex_MemRead  <= id_MemRead;
        ex_MemWrite <= id_MemWrite;
        ex_MemtoReg <= id_MemtoReg;
        ex_ALUSrc   <= id_ALUSrc;
        ex_Branch   <= id_Branch;
        ex_ALUOp    <= id_ALUOp;
      end
      default: begin
        // reset and every kind of bubble clear the whole bank
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_rs1_data <= '0;
        ex_rs2_data <= '0;
        ex_imm      <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_funct    <= '0;
        ex_RegWrite <= 1'b0;
        ex_MemRead  <= 1'b0;
        ex_MemWrite <= 1'b0;
        ex_MemtoReg <= 1'b0;
        ex_ALUSrc   <= 1'b0;
        ex_Branch   <= 1'b0;
        ex_ALUOp    <= '0;
      end
    endcase
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Scoreboard bench for id_ex_stage. A driver applies one input set per
//   cycle, runs a behavioural pipeline model and queues the expected
//   combinational response and the expected post-edge register state. A
//   monitor pops and compares. A second instance with 4-bit counters shares
//   the stimulus so counter saturation is observable.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
    logic        rw, mr, mw, m2r, as, br;
    logic [1:0]  aluop;
  } ex_t;

  typedef struct packed {
    ex_t  f;
    logic flush, hold, rst_n;
  } in_t;

  typedef struct {
    bit   chk;
    logic st;
  } comb_exp_t;

  typedef struct {
    ex_t         ex;
    int unsigned scnt, bcnt;
  } reg_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, id_valid, flush, hold;
  logic [63:0]     id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [3:0]      id_funct;
  logic            id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_Branch;
  logic [1:0]      id_ALUOp;

  logic            ex_valid;
  logic [63:0]     ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_funct;
  logic            ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch;
  logic [1:0]      ex_ALUOp;
  logic            stall, pc_write, ifid_write;
  logic [31:0]     stall_count, bubble_count;

  logic            s_valid;
  logic [63:0]     s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]      s_rs1, s_rs2, s_rd;
  logic [3:0]      s_funct;
  logic            s_rw, s_mr, s_mw, s_m2r, s_as, s_br;
  logic [1:0]      s_aluop;
  logic            s_stall, s_pc_write, s_ifid_write;
  logic [3:0]      s_stall_count, s_bubble_count;

  id_ex_stage #(.XLEN(64), .CNTW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch),
    .id_ALUOp(id_ALUOp), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch),
    .ex_ALUOp(ex_ALUOp), .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_count(stall_count), .bubble_count(bubble_count)
  );

  id_ex_stage #(.XLEN(64), .CNTW(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch),
    .id_ALUOp(id_ALUOp), .flush(flush), .hold(hold),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
    .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct(s_funct),
    .ex_RegWrite(s_rw), .ex_MemRead(s_mr), .ex_MemWrite(s_mw),
    .ex_MemtoReg(s_m2r), .ex_ALUSrc(s_as), .ex_Branch(s_br),
    .ex_ALUOp(s_aluop), .stall(s_stall), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .stall_count(s_stall_count), .bubble_count(s_bubble_count)
  );

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state: what the EX stage should hold right now.
  ex_t         m;
  int unsigned m_scnt, m_bcnt;
  bit          m_known = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int unsigned sat15(input int unsigned v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic step(input in_t s);
    bit   lu;
    logic st;
    @(negedge clk);
    rst_n = s.rst_n; flush = s.flush; hold = s.hold;
    id_valid = s.f.valid; id_pc = s.f.pc; id_rs1_data = s.f.rs1d;
    id_rs2_data = s.f.rs2d; id_imm = s.f.imm;
    id_rs1 = s.f.rs1; id_rs2 = s.f.rs2; id_rd = s.f.rd; id_funct = s.f.funct;
    id_RegWrite = s.f.rw; id_MemRead = s.f.mr; id_MemWrite = s.f.mw;
    id_MemtoReg = s.f.m2r; id_ALUSrc = s.f.as; id_Branch = s.f.br; id_ALUOp = s.f.aluop;

    // A load in EX whose destination (not x0) is read by a valid ID instruction.
    lu = m_known && m.valid && m.mr && (m.rd != 0) && s.f.valid &&
         ((m.rd == s.f.rs1) || (m.rd == s.f.rs2));
    st = (s.hold || lu) && !s.flush;
    comb_q.push_back('{chk: m_known, st: st});

    if (!s.rst_n) begin
      m = '0; m_scnt = 0; m_bcnt = 0; m_known = 1'b1;
    end else if (s.flush) begin
      m = '0; m_bcnt++;
    end else if (s.hold) begin
      m_scnt++;
    end else if (lu) begin
      m = '0; m_scnt++; m_bcnt++;
    end else if (s.f.valid) begin
      m = s.f;
    end else begin
      m = '0;
    end
    reg_q.push_back('{ex: m, scnt: m_scnt, bcnt: m_bcnt});
  endtask

  function automatic in_t mk(input bit v, input int rs1, input int rs2, input int rd,
                             input bit mr, input bit rw);
    in_t s;
    s.f.valid = v;
    s.f.pc    = {$urandom, $urandom};
    s.f.rs1d  = {$urandom, $urandom};
    s.f.rs2d  = {$urandom, $urandom};
    s.f.imm   = {$urandom, $urandom};
    s.f.rs1   = 5'(rs1);
    s.f.rs2   = 5'(rs2);
    s.f.rd    = 5'(rd);
    s.f.funct = 4'($urandom);
    s.f.rw    = rw;
    s.f.mr    = mr;
    s.f.mw    = 1'($urandom);
    s.f.m2r   = mr;
    s.f.as    = 1'($urandom);
    s.f.br    = 1'($urandom);
    s.f.aluop = 2'($urandom);
    s.flush = 1'b0; s.hold = 1'b0; s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic in_t rst_cycle();
    in_t s = mk(1'b0, 0, 0, 0, 1'b0, 1'b0);
    s.rst_n = 1'b0;
    return s;
  endfunction

  // Monitor: combinational outputs after inputs settle, registers after the edge.
  initial begin
    comb_exp_t c;
    reg_exp_t  r;
    forever begin
      @(negedge clk); #2;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        if (c.chk) begin
          check("stall",      64'(stall),      64'(c.st));
          check("pc_write",   64'(pc_write),   64'(!c.st));
          check("ifid_write", 64'(ifid_write), 64'(!c.st));
        end
      end
      @(posedge clk); #1;
      if (reg_q.size() > 0) begin
        r = reg_q.pop_front();
        check("ex_valid",    64'(ex_valid),    64'(r.ex.valid));
        check("ex_pc",       ex_pc,            r.ex.pc);
        check("ex_rs1_data", ex_rs1_data,      r.ex.rs1d);
        check("ex_rs2_data", ex_rs2_data,      r.ex.rs2d);
        check("ex_imm",      ex_imm,           r.ex.imm);
        check("ex_regs",     64'({ex_rs1, ex_rs2, ex_rd, ex_funct}),
                             64'({r.ex.rs1, r.ex.rs2, r.ex.rd, r.ex.funct}));
        check("ex_ctrl",     64'({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
                                  ex_ALUSrc, ex_Branch, ex_ALUOp}),
                             64'({r.ex.rw, r.ex.mr, r.ex.mw, r.ex.m2r,
                                  r.ex.as, r.ex.br, r.ex.aluop}));
        check("stall_count",  64'(stall_count),    64'(r.scnt));
        check("bubble_count", 64'(bubble_count),   64'(r.bcnt));
        check("stall_count_w4",  64'(s_stall_count),  64'(sat15(r.scnt)));
        check("bubble_count_w4", 64'(s_bubble_count), 64'(sat15(r.bcnt)));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t s, lw, add;
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
    id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct = '0;
    id_RegWrite = 1'b0; id_MemRead = 1'b0; id_MemWrite = 1'b0;
    id_MemtoReg = 1'b0; id_ALUSrc = 1'b0; id_Branch = 1'b0; id_ALUOp = '0;

    step(rst_cycle()); step(rst_cycle());

    // lw x5 then dependent add x6,x5,x7: one bubble, add re-presented and latched
    lw  = mk(1'b1, 1, 0, 5, 1'b1, 1'b1);
    add = mk(1'b1, 5, 7, 6, 1'b0, 1'b1);
    step(lw); step(add); step(add); step(mk(1'b0, 0, 0, 0, 1'b0, 1'b0));

    // load into x0 never stalls
    step(rst_cycle());
    step(mk(1'b1, 2, 0, 0, 1'b1, 1'b1));
    step(mk(1'b1, 0, 3, 4, 1'b0, 1'b1));

    // flush and load-use in the same cycle
    step(rst_cycle());
    step(lw);
    s = add; s.flush = 1'b1; step(s);

    // hold with ex_pc = 0x100, then hold+flush
    step(rst_cycle());
    s = mk(1'b1, 1, 2, 3, 1'b0, 1'b1); s.f.pc = 64'h100; step(s);
    for (int i = 0; i < 3; i++) begin
      s = mk(1'b1, 4, 5, 6, 1'b0, 1'b1); s.hold = 1'b1; step(s);
    end
    s.flush = 1'b1; step(s);

    // 20 hold cycles: 4-bit counter saturates at 15
    step(rst_cycle());
    for (int i = 0; i < 20; i++) begin
      s = mk(1'b1, 1, 1, 1, 1'b0, 1'b1); s.hold = 1'b1; step(s);
    end
    step(mk(1'b1, 1, 1, 1, 1'b0, 1'b1));

    // reset during a load-use stall cancels the bubble
    step(lw);
    s = add; s.rst_n = 1'b0; step(s);
    step(add);

    // randomized traffic with a small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      s = mk(($urandom_range(0, 99) < 85), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 99) < 40), 1'($urandom));
      s.flush = ($urandom_range(0, 99) < 8);
      s.hold  = ($urandom_range(0, 99) < 10);
      s.rst_n = !($urandom_range(0, 99) < 2);
      step(s);
    end

    repeat (3) @(negedge clk);
    check("queue_drain", 64'(comb_q.size() + reg_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
